// File: rtl/spi_slave_burst_pkg.sv
// Shared types and constants for the SPI slave burst front end.
package spi_slave_burst_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    WR_BURST,
    READ_ADD,
    READ_DATA,
    WAIT_TX,
    SHIFT_OUT,
    DRAIN
  } state_t;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // True when the received command is legal for the path chosen by the path bit.
  function automatic logic cmd_accepted(input state_t st, input logic [1:0] cmd);
    case (st)
      WRITE:     return (cmd == CMD_WR_ADDR) || (cmd == CMD_WR_DATA);
      READ_ADD:  return (cmd == CMD_RD_ADDR);
      READ_DATA: return (cmd == CMD_RD_DATA);
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/spi_slave_burst_if.sv
// SPI pin side plus RAM rx/tx handshake, bundled for the slave front end.
interface spi_slave_burst_if #(
  parameter int DATA_W = 8
) ();
  localparam int FRAME_W = DATA_W + 2;

  logic               SS_n;
  logic               MOSI;
  logic               MISO;
  logic [FRAME_W-1:0] rx_data;
  logic               rx_valid;
  logic [DATA_W-1:0]  tx_data;
  logic               tx_valid;
  logic               err;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid, err
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid, err
  );
endinterface

// File: rtl/spi_slave_burst_tx_shifter.sv
// MSB-first serialiser for RAM read data; bit_o is the registered MISO value.
module spi_tx_shifter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              bit_o,
  output logic              done_o
);
  localparam int SCNT_W = $clog2(DATA_W + 1);

  // The MSB goes straight to bit_q on load, so only the remaining bits are held here.
  logic [DATA_W-2:0] word_q;
  logic [SCNT_W-1:0] cnt_q;
  logic              bit_q;

  // Load presents the MSB immediately; each shift presents the next bit; clear idles the line.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_q <= 1'b0;
      cnt_q <= '0;
    end else if (clear_i) begin
      bit_q <= 1'b0;
      cnt_q <= '0;
    end else if (load_i) begin
      word_q <= data_i[DATA_W-2:0];
      bit_q  <= data_i[DATA_W-1];
      cnt_q  <= SCNT_W'(1);
    end else if (shift_i) begin
      word_q <= {word_q[DATA_W-3:0], 1'b0};
      bit_q  <= word_q[DATA_W-2];
      cnt_q  <= cnt_q + SCNT_W'(1);
    end
  end

  assign bit_o  = bit_q;
  // High while the last bit of the word is on the line.
  assign done_o = (cnt_q == SCNT_W'(DATA_W));

endmodule

// File: rtl/spi_slave_burst.sv
// SPI slave front end: deserialises {cmd, payload} frames for the RAM, serialises
// RAM read data onto MISO, supports bursts while SS_n stays low, flags bad commands.
module spi_slave_burst
  import spi_slave_burst_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter bit BURST_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  spi_slave_burst_if.slave bus
);
  localparam int FRAME_W = DATA_W + 2;
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] WORD_LAST  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(FRAME_W);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [FRAME_W-2:0] sh_q;
  logic [FRAME_W-1:0] frame_d;
  logic [1:0]         cmd_d;
  logic [FRAME_W-1:0] rx_data_q;
  logic               rx_valid_q;
  logic               err_q;
  logic               rd_addr_seen_q;

  logic tx_load, tx_shift, tx_clear, tx_done, miso_bit;

  // Incoming frame including the bit sampled on this edge.
  assign frame_d = {sh_q, bus.MOSI};
  assign cmd_d   = frame_d[FRAME_W-1 -: 2];
  // Bit counter saturates rather than wrapping.
  assign cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  // Serialiser control: SS_n high or completion idles MISO immediately.
  assign tx_load  = (state_q == WAIT_TX) && !bus.SS_n && bus.tx_valid;
  assign tx_shift = (state_q == SHIFT_OUT) && !bus.SS_n && !tx_done;
  assign tx_clear = (state_q == SHIFT_OUT) && (bus.SS_n || tx_done);

  spi_tx_shifter #(.DATA_W(DATA_W)) u_tx (
    .clk     (clk),
    .rst     (rst),
    .load_i  (tx_load),
    .shift_i (tx_shift),
    .clear_i (tx_clear),
    .data_i  (bus.tx_data),
    .bit_o   (miso_bit),
    .done_o  (tx_done)
  );

  // Main FSM with registered strobes; SS_n high aborts any transfer without a strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      sh_q           <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      err_q          <= 1'b0;
      rd_addr_seen_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      err_q      <= 1'b0;
      if (bus.SS_n && (state_q != IDLE)) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            cnt_q <= '0;
            if (!bus.SS_n) state_q <= CHK_CMD;
          end
          CHK_CMD: begin
            cnt_q <= '0;
            if (!bus.MOSI)          state_q <= WRITE;
            else if (rd_addr_seen_q) state_q <= READ_DATA;
            else                     state_q <= READ_ADD;
          end
          WRITE, READ_ADD, READ_DATA: begin
            sh_q <= frame_d[FRAME_W-2:0];
            if (cnt_q == FRAME_LAST) begin
              cnt_q <= '0;
              if (cmd_accepted(state_q, cmd_d)) begin
                rx_valid_q <= 1'b1;
                rx_data_q  <= frame_d;
                if (state_q == WRITE) begin
                  state_q <= (BURST_EN && (cmd_d == CMD_WR_DATA)) ? WR_BURST : DRAIN;
                end else if (state_q == READ_ADD) begin
                  rd_addr_seen_q <= 1'b1;
                  state_q        <= DRAIN;
                end else begin
                  state_q <= WAIT_TX;
                end
              end else begin
                err_q   <= 1'b1;
                state_q <= DRAIN;
              end
            end else begin
              cnt_q <= cnt_d;
            end
          end
          WR_BURST: begin
            sh_q <= frame_d[FRAME_W-2:0];
            if (cnt_q == WORD_LAST) begin
              cnt_q      <= '0;
              rx_valid_q <= 1'b1;
              rx_data_q  <= {CMD_WR_DATA, frame_d[DATA_W-1:0]};
            end else begin
              cnt_q <= cnt_d;
            end
          end
          WAIT_TX: begin
            if (bus.tx_valid) state_q <= SHIFT_OUT;
          end
          SHIFT_OUT: begin
            if (tx_done) begin
              rd_addr_seen_q <= 1'b0;
              if (BURST_EN) begin
                rx_valid_q <= 1'b1;
                rx_data_q  <= {CMD_RD_DATA, {DATA_W{1'b0}}};
                state_q    <= WAIT_TX;
              end else begin
                state_q <= DRAIN;
              end
            end
          end
          DRAIN: begin
            state_q <= DRAIN;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.MISO     = miso_bit;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.err      = err_q;

endmodule
